// File: rtl/rsa_pkg.sv
// Shared definitions for the rsa_arbiter slice.
//   rsa_arb_state_t : sequencer states of the arbiter FSM
//   RSA_NREQ        : number of requesters sharing one rsa_unit
package rsa_pkg;

    localparam int RSA_NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } rsa_arb_state_t;

endpackage

// File: rtl/rsa_arbiter_if.sv
// Requester-side bus of rsa_arbiter.
//   req      : per-requester request level (bit i = requester i)
//   P_in, E_in, M_in, Const_in : packed operands, slice [i*WIDTH +: WIDTH] = requester i
//   ack      : one-cycle accept pulse, operands sampled that cycle
//   done     : one-cycle completion pulse to the owning requester
//   err      : qualifies done, 1 = watchdog abort
//   result   : result C, held until the next capture
//   busy     : arbiter is not idle
// master = requester side, slave = arbiter side.
interface rsa_arbiter_if #(
    parameter int WIDTH = 8
);
    import rsa_pkg::*;

    logic [RSA_NREQ-1:0]       req;
    logic [RSA_NREQ*WIDTH-1:0] P_in;
    logic [RSA_NREQ*WIDTH-1:0] E_in;
    logic [RSA_NREQ*WIDTH-1:0] M_in;
    logic [RSA_NREQ*WIDTH-1:0] Const_in;
    logic [RSA_NREQ-1:0]       ack;
    logic [RSA_NREQ-1:0]       done;
    logic                      err;
    logic [WIDTH-1:0]          result;
    logic                      busy;

    modport master (
        output req, P_in, E_in, M_in, Const_in,
        input  ack, done, err, result, busy
    );

    modport slave (
        input  req, P_in, E_in, M_in, Const_in,
        output ack, done, err, result, busy
    );

endinterface

// File: rtl/rsa_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin grant.
//   req   : request bits of the two clients
//   prio  : index that wins when both request
//   valid : at least one request present
//   grant : index of the winning client (meaningful only when valid)
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       valid,
    output logic       grant
);

    always_comb begin
        valid = |req;
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = prio;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/rsa_arbiter.sv
// rsa_arbiter: shares one rsa_unit between two requesters.
// Grants round-robin, latches the winner's operands, sequences the unit's
// clear/ena, waits for eoc under a watchdog and returns the result with a
// per-requester done pulse.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : requester-side handshake, operands and result
//   rsa_ena/clear   : control to rsa_unit
//   rsa_P/E/M/Const : registered operands to rsa_unit
//   rsa_C, rsa_eoc  : result and end-of-computation from rsa_unit
// Every output is a flop loaded from the value computed for the current
// state, so the outputs describe a state one cycle after the FSM is in it.
module rsa_arbiter
    import rsa_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    rsa_arbiter_if.slave     bus,
    output logic             rsa_ena,
    output logic             rsa_clear,
    output logic [WIDTH-1:0] rsa_P,
    output logic [WIDTH-1:0] rsa_E,
    output logic [WIDTH-1:0] rsa_M,
    output logic [WIDTH-1:0] rsa_Const,
    input  logic [WIDTH-1:0] rsa_C,
    input  logic             rsa_eoc
);

    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    rsa_arb_state_t state, state_next;

    logic                pick_valid;
    logic                pick_grant;
    logic                prio, prio_next;
    logic                own, own_next;
    logic [WD_W-1:0]     wd, wd_next;
    logic                wd_hit;
    logic                latch_ops;

    logic [RSA_NREQ-1:0] ack_q, ack_next;
    logic [RSA_NREQ-1:0] done_q, done_next;
    logic                err_q, err_next;
    logic                busy_q, busy_next;
    logic [WIDTH-1:0]    result_q, result_next;
    logic                ena_next, clear_next;

    logic [WIDTH-1:0]    p_sel, e_sel, m_sel, c_sel;

    rr_pick2 u_pick (
        .req   (bus.req),
        .prio  (prio),
        .valid (pick_valid),
        .grant (pick_grant)
    );

    assign wd_hit = (wd == WD_MAX);

    // Operand slice belonging to the requester that wins this cycle.
    assign p_sel = pick_grant ? bus.P_in[2*WIDTH-1:WIDTH]     : bus.P_in[WIDTH-1:0];
    assign e_sel = pick_grant ? bus.E_in[2*WIDTH-1:WIDTH]     : bus.E_in[WIDTH-1:0];
    assign m_sel = pick_grant ? bus.M_in[2*WIDTH-1:WIDTH]     : bus.M_in[WIDTH-1:0];
    assign c_sel = pick_grant ? bus.Const_in[2*WIDTH-1:WIDTH] : bus.Const_in[WIDTH-1:0];

    assign bus.ack    = ack_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.result = result_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; eoc is checked before the watchdog so success wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pick_valid) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (rsa_eoc || wd_hit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of every registered output and of the
    // bookkeeping registers (prio, own, wd).
    always_comb begin
        ack_next    = '0;
        done_next   = '0;
        err_next    = err_q;
        busy_next   = (state != IDLE);
        result_next = result_q;
        ena_next    = 1'b0;
        clear_next  = 1'b1;
        prio_next   = prio;
        own_next    = own;
        wd_next     = wd;
        latch_ops   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    ack_next[pick_grant] = 1'b1;
                    latch_ops            = 1'b1;
                    own_next             = pick_grant;
                    prio_next            = ~pick_grant;
                    busy_next            = 1'b1;
                end
            end
            LOAD: begin
                ena_next   = 1'b1;
                clear_next = 1'b1;
                wd_next    = '0;
            end
            RUN: begin
                ena_next   = 1'b1;
                clear_next = 1'b0;
                if (rsa_eoc) begin
                    result_next = rsa_C;
                    err_next    = 1'b0;
                end else if (wd_hit) begin
                    err_next = 1'b1;
                end else begin
                    // Increment only while staying in RUN so wd never wraps.
                    wd_next = wd + WD_W'(1);
                end
            end
            DONE: begin
                done_next[own] = 1'b1;
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    // Output, operand and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            rsa_ena   <= 1'b0;
            rsa_clear <= 1'b1;
            prio      <= 1'b0;
            own       <= 1'b0;
            wd        <= '0;
            rsa_P     <= '0;
            rsa_E     <= '0;
            rsa_M     <= '0;
            rsa_Const <= '0;
        end else begin
            ack_q     <= ack_next;
            done_q    <= done_next;
            err_q     <= err_next;
            busy_q    <= busy_next;
            result_q  <= result_next;
            rsa_ena   <= ena_next;
            rsa_clear <= clear_next;
            prio      <= prio_next;
            own       <= own_next;
            wd        <= wd_next;
            if (latch_ops) begin
                rsa_P     <= p_sel;
                rsa_E     <= e_sel;
                rsa_M     <= m_sel;
                rsa_Const <= c_sel;
            end
        end
    end

endmodule

// File: doc/rsa_arbiter.md
# rsa_arbiter

Round-robin arbiter and sequencer that shares one `rsa_unit` modular-exponentiation datapath between two requesters, e.g. the CPU register interface and a DMA-style key loader.
- Latches the winning requester's operands into holding registers and drives them to the unit.
- Sequences the unit's `clear`/`ena`, waits for `eoc` under a watchdog, and returns the result with a per-requester completion pulse.
- Sits between the peripheral register file and the `rsa_unit` instance.

## Interface
Parameters:
- `WIDTH`, 8: operand width; matches `rsa_unit` WIDTH.
- `TIMEOUT`, 1023: max RUN cycles before abort; counter width `$clog2(TIMEOUT+1)`.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-requester request level; bit i = requester i.
- `P_in`, `E_in`, `M_in`, `Const_in`  in  2*WIDTH each  packed operands; slice [i*WIDTH +: WIDTH] belongs to requester i.
- `ack`  out  2  one-cycle accept pulse; operands sampled that cycle.
- `done`  out  2  one-cycle completion pulse to the owning requester.
- `err`  out  1  qualifies `done`: 1 = watchdog abort, `result` invalid.
- `result`  out  WIDTH  result C; held until the next capture.
- `busy`  out  1  high in every state except IDLE.
- `rsa_ena`, `rsa_clear`  out  1  control outputs to `rsa_unit`.
- `rsa_P`, `rsa_E`, `rsa_M`, `rsa_Const`  out  WIDTH  registered operands to `rsa_unit`.
- `rsa_C`  in  WIDTH  result from `rsa_unit`.
- `rsa_eoc`  in  1  end-of-computation from `rsa_unit`.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE
  - If any `req` bit is high: grant to the requester selected by the priority pointer `prio`.
    - Both requesting: `prio` wins.
    - One requesting: that one wins.
  - Pulse `ack[g]` and latch its operands and the owner index `own`.
  - Flip `prio` to the non-granted index, then go to LOAD.
- LOAD (exactly 1 cycle): `rsa_clear`=1, `rsa_ena`=1; clears the unit's internal FSM/registers. Next state RUN; watchdog counter `wd` = 0.
- RUN
  - `rsa_clear`=0, `rsa_ena`=1, `wd` increments each cycle.
  - On `rsa_eoc`=1: capture `rsa_C` into `result`, set `err`=0, go to DONE.
  - Else if `wd`==TIMEOUT: keep `result`, set `err`=1, go to DONE.
  - `rsa_eoc` and timeout in the same cycle: success wins.
- DONE (1 cycle): pulse `done[own]`; `err` is valid with it. `rsa_ena`=0, `rsa_clear`=1. Next state IDLE.
- `req` is ignored outside IDLE. A requester that drops `req` after `ack` still receives `done`.
- Operands are latched only at `ack`; later changes on `*_in` have no effect on the running job.
- `rsa_*` operand outputs hold their last value between jobs.

## Timing
- Reset values:
  - State IDLE; `prio`=0; `own`=0; `wd`=0.
  - `ack`=0, `done`=0, `err`=0, `busy`=0, `result`=0.
  - `rsa_ena`=0, `rsa_clear`=1; `rsa_P`/`rsa_E`/`rsa_M`/`rsa_Const`=0.
- All outputs are registered. Reset mid-job forces IDLE immediately; no `done` is produced for the aborted job.
- Latency from `req` sampled in IDLE:
  - `ack` in the cycle after the sampling edge.
  - LOAD +1 cycle, RUN N cycles (until `eoc`), `done` at N+3 cycles.
- Back-to-back jobs: the next `ack` comes no earlier than the cycle after `done`. Minimum IDLE dwell is 1 cycle.
- Fairness: with both requesters held high, grants alternate 0,1,0,1, starting from 0 after reset.

## Structure
- Package `rsa_pkg`:
  - State enum `rsa_arb_state_t` {IDLE, LOAD, RUN, DONE}.
  - Requester-count constant `RSA_NREQ = 2`.
- One sub-module: `rr_pick2`, a combinational two-way round-robin grant from `req` and `prio`. It is reusable by other shared peripherals.
- Everything else (FSM, operand registers, watchdog) stays in `rsa_arbiter`.
- The top-level peripheral instantiates `rsa_arbiter` and `rsa_unit` side by side.

## Test plan
- **Single job, real `rsa_unit` (WIDTH=8):** requester 0 with P=7, E=3, M=143, Const=100 (2^20 mod 143).
  - Expect `ack[0]` one cycle later, then `done[0]` with `err`=0 and `result`=57.
  - `busy` is high from `ack` to `done`.
- **Simultaneous requests after reset:** `req`=2'b11 held.
  - Grants go to 0, then 1, then 0.
  - Each `done` hits the correct bit, and no `ack` occurs while `busy`.
- **Operand isolation:** change `P_in` slice 0 to 5 one cycle after `ack[0]`. `result` is still 57.
- **Watchdog:** stub `rsa_eoc` tied 0, TIMEOUT=15.
  - `done` arrives exactly 18 cycles after `ack`, with `err`=1.
  - `result` is unchanged from the previous job.
- **Coincident eoc and timeout:** stub asserts `rsa_eoc` in the same cycle `wd`==TIMEOUT, with `rsa_C`=0x3C.
  - `err`=0 and `result`=0x3C.
- **Reset mid-RUN:** assert `rst` while in RUN.
  - All outputs return to their reset values asynchronously, and no `done` is produced.
  - After release, `req[1]` alone is granted normally.
